// File: rtl/refresh_cmd_responder_if.sv
// Refresher command stream bundle: request/grant handshake plus command payload.
// The refresher drives the master side; the controller responder is the slave.
interface refresh_cmd_responder_if;
    logic        ref_valid;
    logic        ref_ready;
    logic        ref_last;
    logic [16:0] ref_a;
    logic [2:0]  ref_ba;
    logic        ref_cas;
    logic        ref_ras;
    logic        ref_we;

    modport master (
        output ref_valid,
        output ref_last,
        output ref_a,
        output ref_ba,
        output ref_cas,
        output ref_ras,
        output ref_we,
        input  ref_ready
    );

    modport slave (
        input  ref_valid,
        input  ref_last,
        input  ref_a,
        input  ref_ba,
        input  ref_cas,
        input  ref_ras,
        input  ref_we,
        output ref_ready
    );
endinterface

// File: rtl/refresh_cmd_responder.sv
// Refresh command responder: stalls bank machines, grants the refresher, forwards its commands to DFI.
// Optional ACTIVE-state watchdog built when REFRESH_TIMEOUT_EN is defined.
module refresh_cmd_responder #(
    parameter int unsigned IDLE_SETTLE    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    refresh_cmd_responder_if.slave  ref_if,
    input  logic                    banks_idle,
    output logic                    block_banks,
    output logic                    refresh_active,
    output logic                    dfi_cs_n,
    output logic                    dfi_ras_n,
    output logic                    dfi_cas_n,
    output logic                    dfi_we_n,
    output logic [16:0]             dfi_address,
    output logic [2:0]              dfi_bank,
    output logic [15:0]             refresh_count,
    output logic                    timeout_err
);

    if (IDLE_SETTLE < 1 || IDLE_SETTLE > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("refresh_cmd_responder: illegal IDLE_SETTLE or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_GRANT,
        S_ACTIVE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  settle_q, settle_d;
    logic        block_q, block_d;
    logic        active_q, active_d;
    logic        cs_n_q, cs_n_d;
    logic        ras_n_q, ras_n_d;
    logic        cas_n_q, cas_n_d;
    logic        we_n_q, we_n_d;
    logic [16:0] addr_q, addr_d;
    logic [2:0]  bank_q, bank_d;
    logic [15:0] count_q, count_d;

    logic        cmd_any;
    logic        owned;
    logic        fwd;
    logic        is_refresh;
    logic        tmo_fire;

    assign cmd_any    = ref_if.ref_ras | ref_if.ref_cas | ref_if.ref_we;
    assign owned      = (state_q == S_GRANT) || (state_q == S_ACTIVE);
    assign fwd        = owned && cmd_any && !tmo_fire;
    assign is_refresh = ref_if.ref_ras & ref_if.ref_cas & ~ref_if.ref_we;

`ifdef REFRESH_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          terr_q, terr_d;

    assign tmo_fire = (state_q == S_ACTIVE) && !ref_if.ref_last
                   && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog: count ACTIVE cycles, restart on grant, latch the error
    always_comb begin
        tmo_d  = tmo_q;
        terr_d = terr_q;
        if (state_q == S_GRANT) begin
            tmo_d = '0;
        end else if (state_q == S_ACTIVE) begin
            tmo_d = tmo_q + 1'b1;
        end
        if (tmo_fire) begin
            terr_d = 1'b1;
        end
    end

    // Watchdog registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Arbitration: request -> drain until banks settle idle -> grant -> active
    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (ref_if.ref_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!ref_if.ref_valid) begin
                    state_d = S_IDLE;
                end else if (banks_idle) begin
                    settle_d = settle_q + 4'd1;
                    if (settle_d == 4'(IDLE_SETTLE)) begin
                        state_d = S_GRANT;
                    end
                end
            end
            S_GRANT: begin
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (ref_if.ref_last || tmo_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall and ownership flags follow the next state so they change one cycle after the decision
    always_comb begin
        block_d  = (state_d != S_IDLE);
        active_d = (state_d == S_GRANT) || (state_d == S_ACTIVE);
    end

    // DFI command slot: forward refresher commands while owned, NOP otherwise
    always_comb begin
        cs_n_d  = 1'b1;
        ras_n_d = 1'b1;
        cas_n_d = 1'b1;
        we_n_d  = 1'b1;
        addr_d  = addr_q;
        bank_d  = bank_q;
        count_d = count_q;
        if (fwd) begin
            cs_n_d  = 1'b0;
            ras_n_d = ~ref_if.ref_ras;
            cas_n_d = ~ref_if.ref_cas;
            we_n_d  = ~ref_if.ref_we;
            addr_d  = ref_if.ref_a;
            bank_d  = ref_if.ref_ba;
            if (is_refresh) begin
                count_d = count_q + 16'd1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            block_q  <= 1'b0;
            active_q <= 1'b0;
            cs_n_q   <= 1'b1;
            ras_n_q  <= 1'b1;
            cas_n_q  <= 1'b1;
            we_n_q   <= 1'b1;
            addr_q   <= '0;
            bank_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            block_q  <= block_d;
            active_q <= active_d;
            cs_n_q   <= cs_n_d;
            ras_n_q  <= ras_n_d;
            cas_n_q  <= cas_n_d;
            we_n_q   <= we_n_d;
            addr_q   <= addr_d;
            bank_q   <= bank_d;
            count_q  <= count_d;
        end
    end

    assign ref_if.ref_ready = (state_q == S_GRANT);
    assign block_banks      = block_q;
    assign refresh_active   = active_q;
    assign dfi_cs_n         = cs_n_q;
    assign dfi_ras_n        = ras_n_q;
    assign dfi_cas_n        = cas_n_q;
    assign dfi_we_n         = we_n_q;
    assign dfi_address      = addr_q;
    assign dfi_bank         = bank_q;
    assign refresh_count    = count_q;

endmodule

// File: tb/tb_refresh_cmd_responder.sv
// Bench for refresh_cmd_responder: directed scenarios plus random traffic against a behavioural model.
// Define REFRESH_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 16).
module tb_refresh_cmd_responder;
    localparam int SETTLE = 2;
    localparam int TMO    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        banks_idle = 1'b0;
    logic        block_banks, refresh_active;
    logic        dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic [16:0] dfi_address;
    logic [2:0]  dfi_bank;
    logic [15:0] refresh_count;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    refresh_cmd_responder_if rif();

    refresh_cmd_responder #(
        .IDLE_SETTLE(SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .ref_if(rif),
        .banks_idle(banks_idle),
        .block_banks(block_banks),
        .refresh_active(refresh_active),
        .dfi_cs_n(dfi_cs_n),
        .dfi_ras_n(dfi_ras_n),
        .dfi_cas_n(dfi_cas_n),
        .dfi_we_n(dfi_we_n),
        .dfi_address(dfi_address),
        .dfi_bank(dfi_bank),
        .refresh_count(refresh_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: ownership described by "stalled", "owned", "first owned cycle"
    bit          m_blk, m_own, m_gnt, m_terr;
    int          m_idle_run, m_act_cycles;
    bit          m_cs_n, m_ras_n, m_cas_n, m_we_n;
    logic [16:0] m_addr;
    logic [2:0]  m_bank;
    logic [15:0] m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_blk = 0; m_own = 0; m_gnt = 0; m_terr = 0;
        m_idle_run = 0; m_act_cycles = 0;
        m_cs_n = 1; m_ras_n = 1; m_cas_n = 1; m_we_n = 1;
        m_addr = '0; m_bank = '0; m_cnt = '0;
    endtask

    task automatic check_model();
        chk("blk", block_banks, m_blk);
        chk("act", refresh_active, m_own);
        chk("rdy", rif.ref_ready, m_gnt);
        chk("dfi_cmd", {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n},
            {m_cs_n, m_ras_n, m_cas_n, m_we_n});
        chk("dfi_addr", dfi_address, m_addr);
        chk("dfi_bank", dfi_bank, m_bank);
        chk("ref_cnt", refresh_count, m_cnt);
        chk("terr", timeout_err, m_terr);
    endtask

    task automatic model_step(input bit v, l, idl, r, c, w,
                              input logic [16:0] a, input logic [2:0] b);
        bit in_active;
        bit fire;
        in_active = m_own && !m_gnt;
        fire = 0;
`ifdef REFRESH_TIMEOUT_EN
        if (in_active && !l && (m_act_cycles + 1 == TMO)) fire = 1;
`endif
        if (m_own && (r | c | w) && !fire) begin
            m_cs_n = 0; m_ras_n = !r; m_cas_n = !c; m_we_n = !w;
            m_addr = a; m_bank = b;
            if (r && c && !w) m_cnt = m_cnt + 16'd1;
        end else begin
            m_cs_n = 1; m_ras_n = 1; m_cas_n = 1; m_we_n = 1;
        end
        if (!m_blk) begin
            if (v) begin
                m_blk = 1;
                m_idle_run = 0;
            end
        end else if (!m_own) begin
            if (!v) begin
                m_blk = 0;
            end else begin
                m_idle_run = idl ? m_idle_run + 1 : 0;
                if (m_idle_run == SETTLE) begin
                    m_own = 1;
                    m_gnt = 1;
                end
            end
        end else if (m_gnt) begin
            m_gnt = 0;
            m_act_cycles = 0;
        end else if (l || fire) begin
            m_own = 0;
            m_blk = 0;
            if (fire) m_terr = 1;
        end else begin
            m_act_cycles++;
        end
    endtask

    // One clock: compare, drive, advance model; starts and ends on a falling edge
    task automatic step(input bit v, l, idl, r, c, w,
                        input logic [16:0] a, input logic [2:0] b);
        check_model();
        rif.ref_valid = v; rif.ref_last = l; banks_idle = idl;
        rif.ref_ras = r; rif.ref_cas = c; rif.ref_we = w;
        rif.ref_a = a; rif.ref_ba = b;
        model_step(v, l, idl, r, c, w, a, b);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic nop(input bit v, l, idl);
        step(v, l, idl, 0, 0, 0, 17'h0, 3'd0);
    endtask

    task automatic prea(input bit v);
        step(v, 0, 1, 1, 0, 1, 17'h400, 3'd0);
    endtask

    task automatic refr(input bit v);
        step(v, 0, 1, 1, 1, 0, 17'h0, 3'd5);
    endtask

    task automatic do_reset();
        rst_n = 0;
        rif.ref_valid = 0; rif.ref_last = 0; banks_idle = 0;
        rif.ref_ras = 0; rif.ref_cas = 0; rif.ref_we = 0;
        rif.ref_a = '0; rif.ref_ba = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int pulses;
        do_reset();
        chk("rst_blk", block_banks, 0);
        chk("rst_cs_n", dfi_cs_n, 1);
        chk("rst_cnt", refresh_count, 0);

        // Basic sequence
        nop(1, 0, 1);
        chk("basic_blk_rise", block_banks, 1);
        chk("basic_rdy_c1", rif.ref_ready, 0);
        nop(1, 0, 1);
        chk("basic_rdy_c2", rif.ref_ready, 0);
        nop(1, 0, 1);
        chk("basic_rdy_c3", rif.ref_ready, 1);
        prea(1);
        chk("basic_prea_cs", dfi_cs_n, 0);
        chk("basic_prea_addr", dfi_address, 17'h400);
        chk("basic_rdy_once", rif.ref_ready, 0);
        nop(1, 0, 1);
        refr(1);
        chk("basic_ref_cmd", {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}, 4'b0001);
        nop(0, 1, 1);
        chk("basic_count", refresh_count, 1);
        chk("basic_blk_fall", block_banks, 0);
        nop(0, 0, 1);

        // Drain interruption
        do_reset();
        nop(1, 0, 0);
        nop(1, 0, 1);
        chk("drain_rdy_a", rif.ref_ready, 0);
        nop(1, 0, 0);
        chk("drain_rdy_b", rif.ref_ready, 0);
        nop(1, 0, 1);
        chk("drain_rdy_c", rif.ref_ready, 0);
        nop(1, 0, 1);
        chk("drain_grant", rif.ref_ready, 1);
        prea(1);
        refr(1);
        nop(0, 1, 1);

        // Postponed burst of 8 pairs
        do_reset();
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            nop(1, 0, 1);
            if (rif.ref_ready) pulses++;
        end
        for (int i = 0; i < 8; i++) begin
            prea(1);
            if (rif.ref_ready) pulses++;
            chk("burst_blk", block_banks, 1);
            refr(1);
            if (rif.ref_ready) pulses++;
        end
        nop(0, 1, 1);
        chk("burst_count", refresh_count, 8);
        chk("burst_pulses", pulses, 1);

        // Request withdrawn during drain
        do_reset();
        nop(1, 0, 0);
        chk("wd_blk_on", block_banks, 1);
        step(0, 0, 1, 1, 1, 0, 17'h1, 3'd1);
        chk("wd_blk_off", block_banks, 0);
        chk("wd_no_cmd", dfi_cs_n, 1);
        nop(0, 0, 1);

        // Asynchronous reset between PRECHARGE and REFRESH
        do_reset();
        nop(1, 0, 1); nop(1, 0, 1); nop(1, 0, 1);
        prea(1);
        nop(1, 0, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_blk", block_banks, 0);
        chk("arst_act", refresh_active, 0);
        chk("arst_cs_n", dfi_cs_n, 1);
        chk("arst_addr", dfi_address, 0);
        chk("arst_cnt", refresh_count, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        nop(0, 0, 1);

`ifdef REFRESH_TIMEOUT_EN
        // Watchdog: withhold ref_last
        do_reset();
        nop(1, 0, 1); nop(1, 0, 1); nop(1, 0, 1);
        prea(0);
        for (int i = 0; i < TMO - 1; i++) nop(0, 0, 1);
        chk("tmo_not_yet", timeout_err, 0);
        nop(0, 0, 1);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_blk", block_banks, 0);
        chk("tmo_act", refresh_active, 0);
        nop(1, 0, 1); nop(1, 0, 1); nop(1, 0, 1);
        prea(1);
        refr(1);
        nop(0, 1, 1);
        chk("tmo_sticky", timeout_err, 1);
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit v, l, idl, r, c, w;
            v   = ($urandom_range(0, 99) < 60);
            l   = ($urandom_range(0, 99) < 8);
            idl = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 1) == 1) begin
                r = 1'($urandom); c = 1'($urandom); w = 1'($urandom);
            end else begin
                r = 0; c = 0; w = 0;
            end
            step(v, l, idl, r, c, w, 17'($urandom), 3'($urandom));
        end
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
